// File: rtl/ps2_morse_keyer.sv
// ps2_morse_keyer
// Turns PS/2 Set-2 make codes (A-Z, 0-9, Space) into Morse on a single key
// line. Characters are decoded, queued in a DEPTH-entry FIFO and keyed out at
// UNIT_CYCLES clock cycles per Morse unit.
//
// Parameters
//   UNIT_CYCLES  clk cycles per Morse unit (dot length), >= 2
//   DEPTH        FIFO entries, power of 2, 2..64
//   TONE_DIV     sidetone half-period in clk cycles (SIDETONE_EN builds only)
//
// Ports
//   clk            in   system clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   ps2_data       in   received scancode byte
//   ps2_data_strb  in   1-cycle strobe, ps2_data valid
//   morse_out      out  key output, 1 = mark
//   busy           out  FSM not idle or FIFO non-empty
//   fifo_count     out  FIFO occupancy 0..DEPTH
//   overflow       out  1-cycle pulse when a valid character is dropped
//   tone_out       out  sidetone square wave during marks
//
// Build option
//   SIDETONE_EN  when defined, a divider generates tone_out while morse_out=1;
//                otherwise tone_out is tied to 0.
//
// FSM states
//   state  | meaning
//   IDLE   | waiting; pops the FIFO when it holds an entry
//   LOAD   | latches the popped entry, picks first element or word gap
//   MARK   | key down for 1 unit (dot) or 3 units (dash)
//   EGAP   | 1-unit gap between elements of one character
//   LGAP   | 3-unit gap after the last element of a character
//   WGAP   | 4-unit gap for Space

module ps2_morse_keyer #(
    parameter int UNIT_CYCLES = 10_000_000,
    parameter int DEPTH       = 8,
    parameter int TONE_DIV    = 10_000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               ps2_data,
    input  logic                     ps2_data_strb,
    output logic                     morse_out,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic                     tone_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(4 * UNIT_CYCLES);

    localparam logic [TW-1:0] T1        = TW'(UNIT_CYCLES - 1);
    localparam logic [TW-1:0] T3        = TW'(3 * UNIT_CYCLES - 1);
    localparam logic [TW-1:0] T4        = TW'(4 * UNIT_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_ONE = TW'(1);
    localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_FULL  = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MARK,
        S_EGAP,
        S_LGAP,
        S_WGAP
    } state_e;

    // Returns {hit, len[2:0], pat[4:0]}; pat[len-1] is keyed first, 1 = dash.
    function automatic logic [8:0] lookup(input logic [7:0] code);
        logic [8:0] r;
        r = 9'b0;
        case (code)
            8'h1C: r = {1'b1, 3'd2, 5'b00001}; // A
            8'h32: r = {1'b1, 3'd4, 5'b01000}; // B
            8'h21: r = {1'b1, 3'd4, 5'b01010}; // C
            8'h23: r = {1'b1, 3'd3, 5'b00100}; // D
            8'h24: r = {1'b1, 3'd1, 5'b00000}; // E
            8'h2B: r = {1'b1, 3'd4, 5'b00010}; // F
            8'h34: r = {1'b1, 3'd3, 5'b00110}; // G
            8'h33: r = {1'b1, 3'd4, 5'b00000}; // H
            8'h43: r = {1'b1, 3'd2, 5'b00000}; // I
            8'h3B: r = {1'b1, 3'd4, 5'b00111}; // J
            8'h42: r = {1'b1, 3'd3, 5'b00101}; // K
            8'h4B: r = {1'b1, 3'd4, 5'b00100}; // L
            8'h3A: r = {1'b1, 3'd2, 5'b00011}; // M
            8'h31: r = {1'b1, 3'd2, 5'b00010}; // N
            8'h44: r = {1'b1, 3'd3, 5'b00111}; // O
            8'h4D: r = {1'b1, 3'd4, 5'b00110}; // P
            8'h15: r = {1'b1, 3'd4, 5'b01101}; // Q
            8'h2D: r = {1'b1, 3'd3, 5'b00010}; // R
            8'h1B: r = {1'b1, 3'd3, 5'b00000}; // S
            8'h2C: r = {1'b1, 3'd1, 5'b00001}; // T
            8'h3C: r = {1'b1, 3'd3, 5'b00001}; // U
            8'h2A: r = {1'b1, 3'd4, 5'b00001}; // V
            8'h1D: r = {1'b1, 3'd3, 5'b00011}; // W
            8'h22: r = {1'b1, 3'd4, 5'b01001}; // X
            8'h35: r = {1'b1, 3'd4, 5'b01011}; // Y
            8'h1A: r = {1'b1, 3'd4, 5'b01100}; // Z
            8'h45: r = {1'b1, 3'd5, 5'b11111}; // 0
            8'h16: r = {1'b1, 3'd5, 5'b01111}; // 1
            8'h1E: r = {1'b1, 3'd5, 5'b00111}; // 2
            8'h26: r = {1'b1, 3'd5, 5'b00011}; // 3
            8'h25: r = {1'b1, 3'd5, 5'b00001}; // 4
            8'h2E: r = {1'b1, 3'd5, 5'b00000}; // 5
            8'h36: r = {1'b1, 3'd5, 5'b10000}; // 6
            8'h3D: r = {1'b1, 3'd5, 5'b11000}; // 7
            8'h3E: r = {1'b1, 3'd5, 5'b11100}; // 8
            8'h46: r = {1'b1, 3'd5, 5'b11110}; // 9
            8'h29: r = {1'b1, 3'd0, 5'b00000}; // Space
            default: r = 9'b0;
        endcase
        return r;
    endfunction

    function automatic logic pat_bit(input logic [4:0] pat, input logic [2:0] idx);
        logic [4:0] sh;
        sh = pat >> idx;
        return sh[0];
    endfunction

    // ---------------- decode stage ----------------
    logic       prefix_q;
    logic       dec_valid_q;
    logic [7:0] dec_entry_q;
    logic [8:0] lk;

    assign lk = lookup(ps2_data);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prefix_q    <= 1'b0;
            dec_valid_q <= 1'b0;
            dec_entry_q <= 8'h00;
        end else begin
            dec_valid_q <= 1'b0;
            if (ps2_data_strb) begin
                if (prefix_q) begin
                    // byte following F0/E0 is a break or extended code
                    prefix_q <= 1'b0;
                end else if (ps2_data == 8'hF0 || ps2_data == 8'hE0) begin
                    prefix_q <= 1'b1;
                end else begin
                    dec_valid_q <= lk[8];
                    dec_entry_q <= lk[7:0];
                end
            end
        end
    end

    // ---------------- FIFO ----------------
    state_e        state_q, state_d;
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic [7:0]    rd_data_q;
    logic          pop, full, wr_ok, ovf_d;

    assign pop   = (state_q == S_IDLE) && (count_q != '0);
    assign full  = (count_q == CNT_FULL);
    // a pop in the same cycle frees a slot, so a full FIFO still accepts
    assign wr_ok = dec_valid_q && (!full || pop);
    assign ovf_d = dec_valid_q && full && !pop;

    always_comb begin
        count_d = count_q;
        if (wr_ok && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (!wr_ok && pop) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= dec_entry_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= 8'h00;
            overflow  <= 1'b0;
        end else begin
            count_q  <= count_d;
            overflow <= ovf_d;
            if (wr_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q  <= rd_ptr_q + PTR_ONE;
                rd_data_q <= mem_q[rd_ptr_q];
            end
        end
    end

    assign fifo_count = count_q;

    // ---------------- keying FSM ----------------
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    idx_q, idx_d;
    logic [4:0]    pat_q, pat_d;
    logic [2:0]    ld_len;

    assign ld_len = rd_data_q[7:5];

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        idx_d   = idx_q;
        pat_d   = pat_q;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                pat_d = rd_data_q[4:0];
                if (ld_len == 3'd0) begin
                    state_d = S_WGAP;
                    timer_d = T4;
                end else begin
                    state_d = S_MARK;
                    idx_d   = ld_len - 3'd1;
                    timer_d = pat_bit(rd_data_q[4:0], ld_len - 3'd1) ? T3 : T1;
                end
            end
            S_MARK: begin
                if (timer_q == '0) begin
                    if (idx_q == 3'd0) begin
                        state_d = S_LGAP;
                        timer_d = T3;
                    end else begin
                        state_d = S_EGAP;
                        timer_d = T1;
                        idx_d   = idx_q - 3'd1;
                    end
                end else begin
                    timer_d = timer_q - TIMER_ONE;
                end
            end
            S_EGAP: begin
                if (timer_q == '0) begin
                    state_d = S_MARK;
                    timer_d = pat_bit(pat_q, idx_q) ? T3 : T1;
                end else begin
                    timer_d = timer_q - TIMER_ONE;
                end
            end
            S_LGAP, S_WGAP: begin
                if (timer_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q - TIMER_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            idx_q     <= 3'd0;
            pat_q     <= 5'd0;
            morse_out <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            idx_q     <= idx_d;
            pat_q     <= pat_d;
            morse_out <= (state_q == S_MARK);
            busy      <= (state_q != S_IDLE) || (count_q != '0);
        end
    end

    // ---------------- sidetone ----------------
`ifdef SIDETONE_EN
    localparam int DW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(TONE_DIV - 1);
    localparam logic [DW-1:0] DIV_ONE  = DW'(1);

    logic [DW-1:0] tdiv_q;
    logic          tone_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tdiv_q <= '0;
            tone_q <= 1'b0;
        end else if (!morse_out) begin
            tdiv_q <= '0;
            tone_q <= 1'b0;
        end else if (tdiv_q == DIV_LAST) begin
            tdiv_q <= '0;
            tone_q <= ~tone_q;
        end else begin
            tdiv_q <= tdiv_q + DIV_ONE;
        end
    end

    // gating with morse_out forces silence in the first gap cycle
    assign tone_out = tone_q & morse_out;
`else
    // no divider; the expression is constant 0 for any legal TONE_DIV
    assign tone_out = (TONE_DIV < 0);
`endif

endmodule

// File: tb/tb_ps2_morse_keyer.sv
module tb_ps2_morse_keyer;

    localparam int U  = 4;
    localparam int D  = 4;
    localparam int TD = 2;
    localparam int NC = 16384;

    logic       clk;
    logic       rst_n;
    logic [7:0] ps2_data;
    logic       ps2_data_strb;
    logic       morse_out;
    logic       busy;
    logic [2:0] fifo_count;
    logic       overflow;
    logic       tone_out;

    int total = 0;
    int bad   = 0;

    ps2_morse_keyer #(.UNIT_CYCLES(U), .DEPTH(D), .TONE_DIV(TD)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ps2_data      (ps2_data),
        .ps2_data_strb (ps2_data_strb),
        .morse_out     (morse_out),
        .busy          (busy),
        .fifo_count    (fifo_count),
        .overflow      (overflow),
        .tone_out      (tone_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Morse text for each supported make code ('.' dot, '-' dash, "" = space)
    function automatic string morse_of(input logic [7:0] c, output bit ok);
        ok = 1'b1;
        case (c)
            8'h1C: return ".-";    8'h32: return "-...";  8'h21: return "-.-.";
            8'h23: return "-..";   8'h24: return ".";     8'h2B: return "..-.";
            8'h34: return "--.";   8'h33: return "....";  8'h43: return "..";
            8'h3B: return ".---";  8'h42: return "-.-";   8'h4B: return ".-..";
            8'h3A: return "--";    8'h31: return "-.";    8'h44: return "---";
            8'h4D: return ".--.";  8'h15: return "--.-";  8'h2D: return ".-.";
            8'h1B: return "...";   8'h2C: return "-";     8'h3C: return "..-";
            8'h2A: return "...-";  8'h1D: return ".--";   8'h22: return "-..-";
            8'h35: return "-.--";  8'h1A: return "--..";
            8'h45: return "-----"; 8'h16: return ".----"; 8'h1E: return "..---";
            8'h26: return "...--"; 8'h25: return "....-"; 8'h2E: return ".....";
            8'h36: return "-...."; 8'h3D: return "--..."; 8'h3E: return "---..";
            8'h46: return "----."; 8'h29: return "";
            default: begin ok = 1'b0; return ""; end
        endcase
    endfunction

    // ---------------- reference model ----------------
    // exp_mark[j] : key is down in the state that follows clock edge j
    bit    exp_mark [NC];
    string q [$];
    int    cyc = 0;
    int    last_k = -1;
    int    idle_after = -1;   // keyer is idle after this edge
    bit    prefix_m = 0;
    bit    pend = 0;
    string pend_s;
    bit    busy_nx = 0;
    int    exp_busy = 0, exp_cnt = 0, exp_ovf = 0;

    task automatic schedule(input int p, input string s);
        int pos, dur;
        pos = p + 1;          // edge p pops, edge p+1 leaves the load step
        if (s.len() == 0) begin
            pos += 4 * U;
        end else begin
            for (int i = 0; i < s.len(); i++) begin
                dur = (s[i] == 8'h2D) ? 3 * U : U;
                for (int j = pos; j < pos + dur; j++)
                    if (j < NC) exp_mark[j] = 1'b1;
                pos += dur;
                if (i < s.len() - 1) pos += U;
            end
            pos += 3 * U;
        end
        idle_after = pos;
    endtask

    always @(posedge clk) begin
        int    k, pre;
        bit    pop, ok;
        string s;
        k = cyc;
        if (!rst_n) begin
            q.delete();
            prefix_m = 0;
            pend = 0;
            idle_after = k;
            busy_nx = 0;
            exp_busy = 0;
            exp_cnt = 0;
            exp_ovf = 0;
            for (int i = 0; i < NC; i++) exp_mark[i] = 1'b0;
        end else begin
            exp_busy = busy_nx;
            pre = q.size();
            pop = (k > idle_after) && (pre > 0);
            if (pop) begin
                s = q.pop_front();
                schedule(k, s);
            end
            exp_ovf = 0;
            if (pend) begin
                if (pre < D || pop) q.push_back(pend_s);
                else exp_ovf = 1;
            end
            pend = 0;
            if (ps2_data_strb) begin
                if (prefix_m) prefix_m = 0;
                else if (ps2_data == 8'hF0 || ps2_data == 8'hE0) prefix_m = 1;
                else begin
                    pend_s = morse_of(ps2_data, ok);
                    pend = ok;
                end
            end
            exp_cnt = q.size();
            busy_nx = (k < idle_after) || (q.size() > 0);
        end
        last_k = k;
        cyc++;
    end

    // ---------------- compare process ----------------
    int tone_n = 0;
    always @(negedge clk) begin
        int em, et;
        if (!rst_n) begin
            tone_n = 0;
        end else if (last_k >= 1) begin
            em = (last_k - 1 < NC) ? int'(exp_mark[last_k - 1]) : 0;
            tone_n = em ? tone_n + 1 : 0;
`ifdef SIDETONE_EN
            et = em ? (((tone_n - 1) / TD) % 2) : 0;
`else
            et = 0;
`endif
            chk("morse_out", int'(morse_out), em);
            chk("busy", int'(busy), exp_busy);
            chk("fifo_count", int'(fifo_count), exp_cnt);
            chk("overflow", int'(overflow), exp_ovf);
            chk("tone_out", int'(tone_out), et);
        end
    end

    // ---------------- burst monitor ----------------
    bit mon_en = 0;
    int mon_ovf = 0, mon_max = 0, mon_rise = 0;
    bit mon_prev = 0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (overflow) mon_ovf++;
            if (int'(fifo_count) > mon_max) mon_max = int'(fifo_count);
            if (morse_out && !mon_prev) mon_rise++;
            mon_prev = morse_out;
        end
    end

    // ---------------- stimulus ----------------
    logic m [0:127];
    logic b [0:127];
    int   c [0:127];

    task automatic send(input logic [7:0] v);
        @(negedge clk);
        ps2_data = v;
        ps2_data_strb = 1'b1;
        @(posedge clk);
        #1;
        ps2_data_strb = 1'b0;
    endtask

    // samples 1..n taken #1 after each following edge
    task automatic grab(input int n);
        for (int j = 1; j <= n; j++) begin
            @(posedge clk);
            #1;
            m[j] = morse_out;
            b[j] = busy;
            c[j] = int'(fifo_count);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        repeat (3) @(posedge clk);
        #1;
        while (busy && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_bounded", int'(n < 3000), 1);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int fall, rise, mx;
        bit flag_m, flag_c, flag_o, flag_b;
        logic [7:0] d;
        logic [7:0] codes [37];
        codes = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                  8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                  8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A, 8'h45,
                  8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
                  8'h29};

        rst_n = 1'b0;
        ps2_data = 8'h00;
        ps2_data_strb = 1'b0;
        #1;
        chk("reset_morse", int'(morse_out), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_count", int'(fifo_count), 0);
        chk("reset_overflow", int'(overflow), 0);
        chk("reset_tone", int'(tone_out), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // 'E': mark on samples 4..7, LGAP low 8..19, busy drops at 20
        send(8'h24);
        grab(24);
        chk("E_count_1", c[1], 1);
        chk("E_count_2", c[2], 0);
        chk("E_busy_2", int'(b[2]), 1);
        chk("E_morse_3", int'(m[3]), 0);
        chk("E_morse_4", int'(m[4]), 1);
        chk("E_morse_7", int'(m[7]), 1);
        chk("E_morse_8", int'(m[8]), 0);
        chk("E_busy_19", int'(b[19]), 1);
        chk("E_busy_20", int'(b[20]), 0);
        drain();

        // 'A': dot 4, gap 4, dash 12, gap 12
        send(8'h1C);
        grab(40);
        mx = 0;
        for (int j = 1; j <= 40; j++) if (c[j] > mx) mx = c[j];
        chk("A_count_peak", mx, 1);
        chk("A_morse_7", int'(m[7]), 1);
        chk("A_morse_8", int'(m[8]), 0);
        chk("A_morse_11", int'(m[11]), 0);
        chk("A_morse_12", int'(m[12]), 1);
        chk("A_morse_23", int'(m[23]), 1);
        chk("A_morse_24", int'(m[24]), 0);
        chk("A_busy_35", int'(b[35]), 1);
        chk("A_busy_36", int'(b[36]), 0);
        drain();

        // break and extended sequences enqueue nothing
        send(8'hF0); send(8'h1C); send(8'hE0); send(8'h75);
        flag_m = 0; flag_c = 0; flag_o = 0;
        for (int j = 0; j < 12; j++) begin
            @(posedge clk);
            #1;
            if (morse_out) flag_m = 1;
            if (fifo_count != 3'd0) flag_c = 1;
            if (overflow) flag_o = 1;
        end
        chk("break_morse", int'(flag_m), 0);
        chk("break_count", int'(flag_c), 0);
        chk("break_overflow", int'(flag_o), 0);
        drain();

        // six 'T' strobes two cycles apart: five keyed, one dropped
        mon_ovf = 0; mon_max = 0; mon_rise = 0; mon_prev = 0;
        mon_en = 1;
        for (int i = 0; i < 6; i++) begin
            send(8'h2C);
            @(posedge clk);
        end
        drain();
        mon_en = 0;
        chk("burst_overflow_pulses", mon_ovf, 1);
        chk("burst_count_max", mon_max, 4);
        chk("burst_chars_keyed", mon_rise, 5);

        // 'E' Space 'E': 12-cycle LGAP + 16-cycle WGAP + two 2-cycle
        // idle/load handoffs between the two marks
        send(8'h24);
        @(posedge clk);
        send(8'h29);
        @(posedge clk);
        send(8'h24);
        grab(80);
        fall = -1; rise = -1;
        for (int j = 2; j <= 80; j++) begin
            if (fall < 0 && m[j-1] && !m[j]) fall = j;
            else if (fall >= 0 && rise < 0 && !m[j-1] && m[j]) rise = j;
        end
        chk("word_gap_low_cycles", rise - fall, 32);
        drain();

        // reset in the middle of a dash with a second character queued
        send(8'h2C);
        send(8'h2C);
        repeat (6) @(posedge clk);
        #1;
        chk("rst_pre_morse", int'(morse_out), 1);
        chk("rst_pre_count", int'(fifo_count), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_morse", int'(morse_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_count", int'(fifo_count), 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        flag_m = 0; flag_b = 0;
        for (int j = 0; j < 40; j++) begin
            @(posedge clk);
            #1;
            if (morse_out) flag_m = 1;
            if (busy) flag_b = 1;
        end
        chk("post_rst_morse", int'(flag_m), 0);
        chk("post_rst_busy", int'(flag_b), 0);

        // random traffic checked against the model every cycle
        for (int i = 0; i < 3000; i++) begin
            int r;
            @(negedge clk);
            if ($urandom_range(0, 9) == 0) begin
                r = $urandom_range(0, 9);
                if (r < 7) d = codes[$urandom_range(0, 36)];
                else if (r < 8) d = ($urandom_range(0, 1) != 0) ? 8'hF0 : 8'hE0;
                else d = 8'($urandom_range(0, 255));
                ps2_data = d;
                ps2_data_strb = 1'b1;
            end else begin
                ps2_data_strb = 1'b0;
            end
        end
        @(negedge clk);
        ps2_data_strb = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
